// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer that shares one registered ALU between two requesters.
// Issues one operation at a time, captures the ALU result/flags and returns them with a DONE pulse.
module alu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [3:0]       OPCODE0,
    input  logic [3:0]       OPCODE1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic             DONE0,
    output logic             DONE1,
    output logic [1:0]       GNT,
    output logic [WIDTH-1:0] RESULT,
    output logic [3:0]       FLAGS,
    output logic             ERR,
    output logic             BUSY,
    output logic             ALU_EN,
    output logic             ALU_OE,
    output logic [3:0]       ALU_OPCODE,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_CF,
    input  logic             ALU_OF,
    input  logic             ALU_SF,
    input  logic             ALU_ZF
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic [2:0]       cnt_q, cnt_d;

    logic             pick1;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_legal;

    always_comb begin
        // A lone requester always wins; the pointer only breaks ties.
        pick1     = REQ1 && (!REQ0 || ptr_q);
        req_op    = pick1 ? OPCODE1 : OPCODE0;
        req_a     = pick1 ? A1 : A0;
        req_b     = pick1 ? B1 : B0;
        req_legal = (req_op[3] == 1'b0) && (req_op[2:1] != 2'b00);
    end

    // NOTE: every signal gets its default before the case so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    gnt_d    = pick1 ? 2'b10 : 2'b01;
                    opcode_d = req_op;
                    a_d      = req_a;
                    b_d      = req_b;
                    if (req_legal) begin
                        state_d = S_ISSUE;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '0;
                        flags_d  = '0;
                        state_d  = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    result_d = ALU_OUT;
                    flags_d  = {ALU_CF, ALU_OF, ALU_SF, ALU_ZF};
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                ptr_d   = gnt_q[0];
                gnt_d   = 2'b00;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b0;
            gnt_q    <= 2'b00;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign DONE0      = (state_q == S_RESP) && gnt_q[0];
    assign DONE1      = (state_q == S_RESP) && gnt_q[1];
    assign GNT        = gnt_q;
    assign RESULT     = result_q;
    assign FLAGS      = flags_q;
    assign ERR        = err_q;
    assign BUSY       = (state_q != S_IDLE);
    assign ALU_EN     = (state_q == S_ISSUE);
    assign ALU_OE     = (state_q == S_WAIT);
    assign ALU_OPCODE = opcode_q;
    assign ALU_A      = a_q;
    assign ALU_B      = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each driven by a small registered-ALU model that outputs junk until its latency elapses.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;

    // Instance A: ALU_LAT = 1
    logic       req0, req1;
    logic [3:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       done0, done1, err, busy, alu_en, alu_oe;
    logic [1:0] gnt;
    logic [7:0] result, alu_a, alu_b, alu_out;
    logic [3:0] flags, alu_opcode;
    logic       alu_cf, alu_of, alu_sf, alu_zf;

    // Instance B: ALU_LAT = 3
    logic       req0_b, req1_b;
    logic [3:0] op0_b, op1_b;
    logic [7:0] a0_b, b0_b, a1_b, b1_b;
    logic       done0_b, done1_b, err_b, busy_b, alu_en_b, alu_oe_b;
    logic [1:0] gnt_b;
    logic [7:0] result_b, alu_a_b, alu_b_b, alu_out_b;
    logic [3:0] flags_b, alu_opcode_b;
    logic       alu_cf_b, alu_of_b, alu_sf_b, alu_zf_b;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.WIDTH(8), .ALU_LAT(1)) u_dut_a (
        .CLK(clk), .RST_N(rst_n),
        .REQ0(req0), .REQ1(req1), .OPCODE0(op0), .OPCODE1(op1),
        .A0(a0), .B0(b0), .A1(a1), .B1(b1),
        .DONE0(done0), .DONE1(done1), .GNT(gnt), .RESULT(result), .FLAGS(flags),
        .ERR(err), .BUSY(busy), .ALU_EN(alu_en), .ALU_OE(alu_oe),
        .ALU_OPCODE(alu_opcode), .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OUT(alu_out),
        .ALU_CF(alu_cf), .ALU_OF(alu_of), .ALU_SF(alu_sf), .ALU_ZF(alu_zf)
    );

    alu_arbiter #(.WIDTH(8), .ALU_LAT(3)) u_dut_b (
        .CLK(clk), .RST_N(rst_n),
        .REQ0(req0_b), .REQ1(req1_b), .OPCODE0(op0_b), .OPCODE1(op1_b),
        .A0(a0_b), .B0(b0_b), .A1(a1_b), .B1(b1_b),
        .DONE0(done0_b), .DONE1(done1_b), .GNT(gnt_b), .RESULT(result_b), .FLAGS(flags_b),
        .ERR(err_b), .BUSY(busy_b), .ALU_EN(alu_en_b), .ALU_OE(alu_oe_b),
        .ALU_OPCODE(alu_opcode_b), .ALU_A(alu_a_b), .ALU_B(alu_b_b), .ALU_OUT(alu_out_b),
        .ALU_CF(alu_cf_b), .ALU_OF(alu_of_b), .ALU_SF(alu_sf_b), .ALU_ZF(alu_zf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {CF,OF,SF,ZF,result}.
    function automatic logic [11:0] alu_calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       cf, of;
        w = '0; r = '0; cf = 1'b0; of = 1'b0;
        case (op)
            4'h2: begin
                w  = {1'b0, a} + {1'b0, b};
                r  = w[7:0];
                cf = w[8];
                of = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h3: begin
                r  = a - b;
                cf = (a < b);
                of = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = ~a;
            default: r = 8'h00;
        endcase
        return {cf, of, r[7], (r == 8'h00), r};
    endfunction

    // Registered ALU models: outputs read 0xEE / flags 0xF until LAT edges after EN.
    logic [11:0] pend_a, pend_b;
    int          age_a, age_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_a <= 0; pend_a <= '0;
        end else if (alu_en) begin
            pend_a <= alu_calc(alu_opcode, alu_a, alu_b); age_a <= 1;
        end else if (age_a != 0 && age_a < 15) begin
            age_a <= age_a + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_b <= 0; pend_b <= '0;
        end else if (alu_en_b) begin
            pend_b <= alu_calc(alu_opcode_b, alu_a_b, alu_b_b); age_b <= 1;
        end else if (age_b != 0 && age_b < 15) begin
            age_b <= age_b + 1;
        end
    end

    assign alu_out = (age_a >= 1) ? pend_a[7:0] : 8'hEE;
    assign {alu_cf, alu_of, alu_sf, alu_zf} = (age_a >= 1) ? pend_a[11:8] : 4'hF;
    assign alu_out_b = (age_b >= 3) ? pend_b[7:0] : 8'hEE;
    assign {alu_cf_b, alu_of_b, alu_sf_b, alu_zf_b} = (age_b >= 3) ? pend_b[11:8] : 4'hF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts edges from the current negedge until a DONE on instance A; cyc=-1 on timeout.
    task automatic wait_done(output int cyc, output int en_cnt, output int oe_cnt, output logic who);
        cyc = -1; en_cnt = 0; oe_cnt = 0; who = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            en_cnt += int'(alu_en);
            oe_cnt += int'(alu_oe);
            if (done0 || done1) begin
                cyc = k;
                who = done1;
                break;
            end
        end
    endtask

    logic [3:0] op_tab  [0:1][0:3] = '{'{4'h2, 4'h3, 4'h6, 4'h7}, '{4'h2, 4'h5, 4'h4, 4'h3}};
    logic [7:0] a_tab   [0:1][0:3] = '{'{8'h10, 8'h20, 8'h0F, 8'hF0}, '{8'hFF, 8'h00, 8'hF0, 8'h00}};
    logic [7:0] b_tab   [0:1][0:3] = '{'{8'h20, 8'h20, 8'hF0, 8'h00}, '{8'h01, 8'h00, 8'h3C, 8'h01}};
    logic [7:0] res_tab [0:1][0:3] = '{'{8'h30, 8'h00, 8'hFF, 8'h0F}, '{8'h00, 8'h00, 8'h30, 8'hFF}};
    logic [3:0] flg_tab [0:1][0:3] = '{'{4'b0000, 4'b0001, 4'b0010, 4'b0000},
                                       '{4'b1001, 4'b0001, 4'b0000, 4'b1010}};

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, en_c, oe_c;
        logic who;
        int   idx0, idx1;

        rst_n = 1'b0;
        req0 = 0; req1 = 0; op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        req0_b = 0; req1_b = 0; op0_b = '0; op1_b = '0; a0_b = '0; b0_b = '0; a1_b = '0; b1_b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", {done0, done1, gnt, err, busy, alu_en, alu_oe}, 8'h00);
        check("rst_data", {result, flags, alu_opcode, alu_a, alu_b}, 32'h0);
        rst_n = 1'b1;
        step();

        // REQ0 alone: ADD 0x55 + 0x3C
        op0 = 4'h2; a0 = 8'h55; b0 = 8'h3C; req0 = 1'b1;
        wait_done(cyc, en_c, oe_c, who);
        check("add_cycle", cyc, 3);
        check("add_en_cnt", en_c, 1);
        check("add_owner", {done1, done0}, 2'b01);
        check("add_result", result, 8'h91);
        check("add_flags", flags, 4'b0110);
        check("add_gnt_err", {gnt, err, busy}, 4'b0101);
        req0 = 1'b0;
        step();
        check("add_idle", {done0, done1, gnt, busy}, 5'b0);

        // Reset in WAIT after the pointer moved to 1; afterwards REQ0 must win the tie
        op0 = 4'h6; a0 = 8'hAA; b0 = 8'h55; req0 = 1'b1;
        step();
        step();
        check("rst_pre_wait", {alu_oe, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {done0, done1, gnt, err, busy, alu_en, alu_oe}, 8'h00);
        check("rst_mid_data", {result, flags, alu_opcode, alu_a, alu_b}, 32'h0);
        step();
        check("rst_no_done", {done0, done1}, 2'b00);
        op1 = 4'h2; a1 = 8'h01; b1 = 8'h02; req1 = 1'b1;
        rst_n = 1'b1;
        wait_done(cyc, en_c, oe_c, who);
        check("rec_owner", who, 0);
        check("rec_cycle", cyc, 3);
        check("rec_result", {result, flags}, {8'hFF, 4'b0010});
        req0 = 1'b0;
        wait_done(cyc, en_c, oe_c, who);
        check("rec1_owner", who, 1);
        check("rec1_cycle", cyc, 4);
        check("rec1_result", {result, flags}, {8'h03, 4'b0000});
        req1 = 1'b0;
        step();

        // Simultaneous requests: REQ0 AND then REQ1 OR
        op0 = 4'h4; a0 = 8'hCC; b0 = 8'hAA;
        op1 = 4'h5; a1 = 8'hF0; b1 = 8'h0F;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(cyc, en_c, oe_c, who);
        check("both_first", {done1, done0, gnt}, 4'b0101);
        check("both_first_res", {result, flags}, {8'h88, 4'b0010});
        req0 = 1'b0;
        wait_done(cyc, en_c, oe_c, who);
        check("both_second", {done1, done0, gnt}, 4'b1010);
        check("both_second_res", {result, flags}, {8'hFF, 4'b0010});
        check("both_second_cyc", cyc, 4);
        req1 = 1'b0;
        step();

        // Both held for four ops each: strict alternation, 4-cycle DONE spacing
        idx0 = 0; idx1 = 0;
        op0 = op_tab[0][0]; a0 = a_tab[0][0]; b0 = b_tab[0][0];
        op1 = op_tab[1][0]; a1 = a_tab[1][0]; b1 = b_tab[1][0];
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_done(cyc, en_c, oe_c, who);
            check("rr_owner", who, k % 2);
            check("rr_spacing", cyc, (k == 0) ? 3 : 4);
            if (!who) begin
                check("rr_res0", {result, flags}, {res_tab[0][idx0 % 4], flg_tab[0][idx0 % 4]});
                idx0++;
                if (idx0 < 4) begin
                    op0 = op_tab[0][idx0]; a0 = a_tab[0][idx0]; b0 = b_tab[0][idx0];
                end else begin
                    req0 = 1'b0;
                end
            end else begin
                check("rr_res1", {result, flags}, {res_tab[1][idx1 % 4], flg_tab[1][idx1 % 4]});
                idx1++;
                if (idx1 < 4) begin
                    op1 = op_tab[1][idx1]; a1 = a_tab[1][idx1]; b1 = b_tab[1][idx1];
                end else begin
                    req1 = 1'b0;
                end
            end
            if (cyc < 0) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Illegal opcode on REQ1: straight to RESP with ERR
        op1 = 4'hF; a1 = 8'h12; b1 = 8'h34; req1 = 1'b1;
        wait_done(cyc, en_c, oe_c, who);
        check("ill_cycle", cyc, 1);
        check("ill_en_cnt", en_c, 0);
        check("ill_owner", {done1, done0, gnt}, 4'b1010);
        check("ill_err_res", {err, result, flags}, {1'b1, 8'h00, 4'h0});
        req1 = 1'b0;
        step();
        check("ill_clear", {err, gnt, busy, alu_en}, 5'b0);

        // ALU_LAT=3 instance: REQ1 SUB 0x93 - 0x5A
        op1_b = 4'h3; a1_b = 8'h93; b1_b = 8'h5A; req1_b = 1'b1;
        cyc = -1; en_c = 0; oe_c = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            en_c += int'(alu_en_b);
            oe_c += int'(alu_oe_b);
            if (done0_b || done1_b) begin
                cyc = k;
                break;
            end
        end
        check("lat3_cycle", cyc, 5);
        check("lat3_en_cnt", en_c, 1);
        check("lat3_oe_cnt", oe_c, 3);
        check("lat3_owner", {done1_b, done0_b, gnt_b}, 4'b1010);
        check("lat3_result", {result_b, flags_b}, {8'h39, 4'b0100});
        req1_b = 1'b0;
        step();
        check("lat3_idle", {busy_b, done1_b}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered ALU instance (8-bit, opcode-driven, EN/OE-controlled, CF/OF/SF/ZF flags) between two requesters. It accepts one operation at a time, drives the ALU's EN/OE/OPCODE/A/B, waits the ALU latency, and captures the result and flags. It returns them to the granted requester with a one-cycle DONE pulse. It sits between the ALU and the two datapath clients.

Parameters:
WIDTH, 8, operand/result width; must match the ALU.
ALU_LAT, 1, cycles from the EN-sampling edge to a valid ALU_OUT; legal range 1..7.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous, active-low reset.
REQ0, REQ1  input  1  request; held high with operands stable until the matching DONE.
OPCODE0, OPCODE1  input  4  requested operation.
A0, B0, A1, B1  input  WIDTH  operands.
DONE0, DONE1  output  1  one-cycle completion pulse.
GNT  output  2  one-hot owner, valid from ISSUE through RESP.
RESULT  output  WIDTH  captured ALU result, valid while DONEx=1.
FLAGS  output  4  captured {CF,OF,SF,ZF}, valid while DONEx=1.
ERR  output  1  illegal opcode, valid while DONEx=1.
BUSY  output  1  high in any state other than IDLE.
ALU_EN, ALU_OE  output  1  ALU enable and output enable.
ALU_OPCODE  output  4  to ALU.
ALU_A, ALU_B  output  WIDTH  to ALU.
ALU_OUT  input  WIDTH  from ALU.
ALU_CF, ALU_OF, ALU_SF, ALU_ZF  input  1  from ALU.

Behaviour:
- Reset (async, RST_N=0): state=IDLE; DONE0/1, GNT, RESULT, FLAGS, ERR, BUSY, ALU_EN, ALU_OE, ALU_OPCODE, ALU_A, ALU_B all 0; priority pointer=0 (REQ0 favoured). Reset asserted in any state aborts the operation; no DONE is issued.
- Legal opcodes: 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT_A. All others are illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP, all registered.
- IDLE:
  - No REQ: stay in IDLE.
  - One REQ: grant that requester.
  - Both REQ: grant the requester selected by the pointer.
  - On grant: latch opcode/A/B, set GNT.
  - Legal opcode: go to ISSUE.
  - Illegal opcode: set ERR=1, RESULT=0, FLAGS=0, go directly to RESP. The ALU is never enabled.
- ISSUE: ALU_EN=1 for exactly this cycle, with the latched operands driven. Load the wait counter with ALU_LAT. Go to WAIT.
- WAIT: ALU_EN=0, ALU_OE=1, operands held. Decrement the counter each cycle. In the cycle where the counter equals 1, capture ALU_OUT into RESULT and the flags into FLAGS at the closing edge, then go to RESP.
- RESP:
  - DONEx=1 for the granted requester only; RESULT/FLAGS/ERR held; ALU_OE=0.
  - Pointer := other requester.
  - Next edge: clear GNT and ERR, go to IDLE.
  - REQ is not sampled in RESP.
  - The requester drops REQ on the edge where it samples DONE.
- Timing: REQ sampled in IDLE at cycle 0. DONE occurs at cycle 2+ALU_LAT for legal ops, and at cycle 1 for illegal ops.
- Throughput: one legal op per 3+ALU_LAT cycles.
- BUSY=1 in ISSUE, WAIT and RESP.
- REQ changes while not owned are ignored until IDLE.
- An owner deasserting REQ mid-operation does not abort it; DONE is still issued.
- Arithmetic semantics belong to the ALU. The arbiter passes RESULT/FLAGS through unmodified.

Test Plan:
- REQ0 alone, ADD A0=0x55 B0=0x3C, ALU_LAT=1 -> ALU_EN high exactly 1 cycle; DONE0 at cycle 3; RESULT=0x91, FLAGS={CF=0,OF=1,SF=1,ZF=0}; DONE1 stays 0.
- REQ0 and REQ1 together after reset: REQ0 AND 0xCC,0xAA; REQ1 OR 0xF0,0x0F -> DONE0 first with RESULT=0x88; then DONE1 with 0xFF, GNT=10.
- Both held continuously with 4 ops each -> grants alternate 0,1,0,1...; neither requester starves; DONE spacing is 4 cycles (ALU_LAT=1).
- REQ1 opcode=1111 -> DONE1 at cycle 1 with ERR=1, RESULT=0x00; ALU_EN never asserted.
- RST_N pulsed low during WAIT (REQ0 XOR 0xAA,0x55) -> all outputs 0 immediately; no DONE; pointer=0; the next request completes normally with RESULT=0xFF.
- ALU_LAT=3, REQ1 SUB 0x93,0x5A -> ALU_OE high 3 cycles; DONE1 at cycle 5; RESULT=0x39.
